data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH, default 1024, number of RAM words (power of 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, console FIFO entries (power of 2).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port MemWrite, input, 1, store request this cycle.
REQ-007 SHALL have port MemWriteSelect, input, 4, byte-lane write enables; bit i writes WriteData[8i+7:8i].
REQ-008 SHALL have port ALUResult, input, XLEN, byte address from the core.
REQ-009 SHALL have port WriteData, input, XLEN, store data.
REQ-010 SHALL have port ReadData, output, XLEN, load data for ALUResult.
REQ-011 SHALL have port ConsoleValid, output, 1, FIFO head valid.
REQ-012 SHALL have port ConsoleData, output, 8, FIFO head byte.
REQ-013 SHALL have port ConsoleReady, input, 1, sink accepts head byte.
REQ-014 SHALL have port AccessFault, output, 1, sticky fault flag (STATUS bit3).

Function
REQ-015 RAM region: ALUResult < DEPTH*4; word index ALUResult[log2(DEPTH)+1:2].
REQ-016 ReadData SHALL be combinational (zero latency) from the current ALUResult, matching the core's same-cycle memory stage.
REQ-017 A store SHALL update only the enabled byte lanes at the next rising edge; MemWriteSelect=0 with MemWrite=1 writes nothing.
REQ-018 A same-cycle load of the address being stored SHALL return the old data (write takes effect after the edge).
REQ-019 MMIO region base 0xFFFF_0000: +0x0 CYCLE_LO (RO), +0x4 CYCLE_HI (RO), +0x8 CONSOLE_TX (WO, reads 0), +0xC STATUS.
REQ-020 64-bit cycle counter SHALL increment every cycle out of reset, wrap 2^64-1 -> 0; writes to CYCLE_* ignored.
REQ-021 STATUS bits: [0] FIFO full, [1] FIFO empty, [2] overflow sticky, [3] fault sticky, others read 0; writing 1 to bit2/bit3 clears it, other bits ignore writes.
REQ-022 Store to CONSOLE_TX with MemWriteSelect[0]=1 SHALL push WriteData[7:0]; if FIFO full, byte dropped and overflow set.
REQ-023 FIFO pop SHALL occur when ConsoleValid && ConsoleReady; ConsoleValid = !empty; ConsoleData = head, stable while not popped.
REQ-024 Simultaneous push and pop when full SHALL succeed (pop frees slot same edge, no overflow); when empty the pushed byte appears next cycle.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy 0..FIFO_DEPTH tracked with extra bit.
REQ-026 Fault SHALL set on any access (MemWrite=1 or load-side decode outside RAM/MMIO) to an unmapped address, or MemWrite with ALUResult[1:0]!=0; faulting store writes nothing; unmapped reads return 0.
REQ-027 Fault detection for loads SHALL be qualified by input ALUResult only when MemWrite=0 and address decodes to unmapped — bench drives ALUResult=0 when idle.
REQ-028 Set and clear of a sticky bit in the same cycle: set wins.

Reset
REQ-029 On reset: cycle counter 0, FIFO empty (ConsoleValid 0, ConsoleData 0), overflow 0, AccessFault 0.
REQ-030 RAM contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted mid-transfer SHALL discard FIFO contents and ignore same-cycle store.

Configuration
REQ-032 Macro DATA_MEM_CONSOLE_EN: defined -> console FIFO and CONSOLE_TX as above; undefined -> no FIFO, ConsoleValid tied 0, ConsoleData 0, CONSOLE_TX writes ignored without overflow, STATUS[0]=1,[1]=1,[2]=0.

Verification
REQ-033 Store 0xDEADBEEF to 0x10 sel=1111, then sel=0010 data 0x0000AA00 -> read 0x10 = 0xDEADAABE... corrected: = 0xDEADAAEF.
REQ-034 Reset, idle 5 cycles, read 0xFFFF_0000 -> 5 (±0 per counter definition, counter counts cycles after reset deassert).
REQ-035 ConsoleReady=0, push 9 bytes 0x41..0x49 -> STATUS=0x5 (full+overflow), then ConsoleReady=1 drains 0x41..0x48 in order, STATUS=0x6.
REQ-036 FIFO full, push 0x5A with ConsoleReady=1 same cycle -> no overflow, 0x5A last out.
REQ-037 Store to 0x0000_8000 (DEPTH=1024) -> AccessFault=1, RAM unchanged; write 0x8 to STATUS -> AccessFault=0.
REQ-038 Reset asserted with 3 bytes queued -> next cycle ConsoleValid=0, STATUS=0x2.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM with byte-lane stores, MMIO cycle counter, console TX FIFO
// and a sticky fault flag. The console FIFO is only built when DATA_MEM_CONSOLE_EN is defined.
module data_mem_responder #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic [3:0]      MemWriteSelect,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] ReadData,
    output logic            ConsoleValid,
    output logic [7:0]      ConsoleData,
    input  logic            ConsoleReady,
    output logic            AccessFault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] MmioBase = XLEN'(32'hFFFF_0000);

    logic [XLEN-1:0] mem [DEPTH];
    logic [63:0]     cycleCount;
    logic            overflowQ;
    logic            faultQ;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            overflowSet;

    logic          isRam;
    logic          isMmio;
    logic [1:0]    mmioOff;
    logic [AW-1:0] wordIdx;
    logic          faultNow;
    logic          goodStore;
    logic          ramWe;
    logic          statusWr;

    assign isRam     = (ALUResult >> (AW + 2)) == '0;
    assign isMmio    = ALUResult[XLEN-1:4] == MmioBase[XLEN-1:4];
    assign mmioOff   = ALUResult[3:2];
    assign wordIdx   = ALUResult[AW+1:2];
    // Unmapped addresses fault on loads and stores; misalignment only matters for stores.
    assign faultNow  = (!isRam && !isMmio) || (MemWrite && (ALUResult[1:0] != 2'b00));
    assign goodStore = MemWrite && !faultNow && !reset;
    assign ramWe     = goodStore && isRam;
    assign statusWr  = goodStore && isMmio && (mmioOff == 2'd3) && MemWriteSelect[0];

    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (MemWriteSelect[i]) begin
                    mem[wordIdx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (isRam) begin
            ReadData = mem[wordIdx];
        end else if (isMmio) begin
            case (mmioOff)
                2'd0:    ReadData = XLEN'(cycleCount[31:0]);
                2'd1:    ReadData = XLEN'(cycleCount[63:32]);
                2'd3:    ReadData = XLEN'({faultQ, overflowQ, fifoEmpty, fifoFull});
                default: ReadData = '0;
            endcase
        end
    end

    // Sticky bits: a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
            overflowQ  <= 1'b0;
            faultQ     <= 1'b0;
        end else begin
            cycleCount <= cycleCount + 64'd1;
            if (overflowSet) begin
                overflowQ <= 1'b1;
            end else if (statusWr && WriteData[2]) begin
                overflowQ <= 1'b0;
            end
            if (faultNow) begin
                faultQ <= 1'b1;
            end else if (statusWr && WriteData[3]) begin
                faultQ <= 1'b0;
            end
        end
    end

    assign AccessFault = faultQ;

`ifdef DATA_MEM_CONSOLE_EN
    localparam int unsigned FW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = FW + 1;

    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [FW-1:0]   wrPtr;
    logic [FW-1:0]   rdPtr;
    logic [CntW-1:0] fifoCount;
    logic            txReq;
    logic            push;
    logic            pop;

    assign fifoFull    = fifoCount == CntW'(FIFO_DEPTH);
    assign fifoEmpty   = fifoCount == '0;
    assign pop         = !fifoEmpty && ConsoleReady;
    assign txReq       = goodStore && isMmio && (mmioOff == 2'd2) && MemWriteSelect[0];
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push        = txReq && (!fifoFull || pop);
    assign overflowSet = txReq && fifoFull && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= WriteData[7:0];
        end
    end

    assign ConsoleValid = !fifoEmpty;
    assign ConsoleData  = fifoEmpty ? 8'h00 : fifoMem[rdPtr];
`else
    logic unusedReady;

    assign unusedReady  = ConsoleReady;
    assign fifoFull     = 1'b1;
    assign fifoEmpty    = 1'b1;
    assign overflowSet  = 1'b0;
    assign ConsoleValid = 1'b0;
    assign ConsoleData  = 8'h00;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; console checks follow DATA_MEM_CONSOLE_EN.
module tb_data_mem_responder;

    localparam logic [31:0] CycLo    = 32'hFFFF_0000;
    localparam logic [31:0] CycHi    = 32'hFFFF_0004;
    localparam logic [31:0] TxAddr   = 32'hFFFF_0008;
    localparam logic [31:0] StatAddr = 32'hFFFF_000C;
`ifdef DATA_MEM_CONSOLE_EN
    localparam logic [31:0] StEmpty  = 32'h2;
`else
    localparam logic [31:0] StEmpty  = 32'h3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [3:0]  MemWriteSelect;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        ConsoleValid;
    logic [7:0]  ConsoleData;
    logic        ConsoleReady;
    logic        AccessFault;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .MemWrite      (MemWrite),
        .MemWriteSelect(MemWriteSelect),
        .ALUResult     (ALUResult),
        .WriteData     (WriteData),
        .ReadData      (ReadData),
        .ConsoleValid  (ConsoleValid),
        .ConsoleData   (ConsoleData),
        .ConsoleReady  (ConsoleReady),
        .AccessFault   (AccessFault)
    );

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        ALUResult      = addr;
        WriteData      = data;
        MemWriteSelect = sel;
        MemWrite       = 1'b1;
        tick();
        MemWrite       = 1'b0;
        MemWriteSelect = 4'h0;
        ALUResult      = 32'h0;
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ALUResult = addr;
        #1;
        checkEq(tag, ReadData, exp);
        ALUResult = 32'h0;
    endtask

`ifdef DATA_MEM_CONSOLE_EN
    task automatic drain(input string tag, input logic [7:0] first, input int n);
        logic [7:0] e;
        ConsoleReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = first + 8'(i);
            #1;
            checkEq($sformatf("%s%0d", tag, i), {ConsoleValid, ConsoleData}, {1'b1, e});
            tick();
        end
        ConsoleReady = 1'b0;
    endtask
`endif

    initial begin
        reset          = 1'b1;
        MemWrite       = 1'b0;
        MemWriteSelect = 4'h0;
        ALUResult      = 32'h0;
        WriteData      = 32'h0;
        ConsoleReady   = 1'b0;
        repeat (2) tick();
        checkEq("rstValid", ConsoleValid, 1'b0);
        checkEq("rstData", ConsoleData, 8'h00);
        checkEq("rstFault", AccessFault, 1'b0);
        checkRead("rstCycle", CycLo, 32'h0);
        reset = 1'b0;

        repeat (5) tick();
        checkRead("cycleLo5", CycLo, 32'd5);
        checkRead("cycleHi", CycHi, 32'h0);
        checkRead("statusIdle", StatAddr, StEmpty);
        checkRead("txReadsZero", TxAddr, 32'h0);

        // Byte-lane merge and empty-lane store
        store(32'h10, 32'hDEADBEEF, 4'hF);
        store(32'h10, 32'h0000AA00, 4'b0010);
        checkRead("laneMerge", 32'h10, 32'hDEADAAEF);
        store(32'h10, 32'h0, 4'h0);
        checkRead("selZero", 32'h10, 32'hDEADAAEF);

        ALUResult      = 32'h10;
        WriteData      = 32'h12345678;
        MemWriteSelect = 4'hF;
        MemWrite       = 1'b1;
        #1;
        checkEq("sameCycleOld", ReadData, 32'hDEADAAEF);
        tick();
        MemWrite       = 1'b0;
        MemWriteSelect = 4'h0;
        #1;
        checkEq("afterEdgeNew", ReadData, 32'h12345678);
        ALUResult = 32'h0;

        store(32'hFFC, 32'hCAFEF00D, 4'hF);
        store(32'h0, 32'hA5A5A5A5, 4'hF);
        store(32'h20, 32'h01020304, 4'hF);
        checkRead("lastWord", 32'hFFC, 32'hCAFEF00D);
        checkRead("word0", 32'h0, 32'hA5A5A5A5);
        store(CycLo, 32'hFFFFFFFF, 4'hF);
        checkEq("noFaultYet", AccessFault, 1'b0);

        // Out-of-range store: faults and must not alias onto word 0
        store(32'h8000, 32'h11111111, 4'hF);
        #1;
        checkEq("faultSet", AccessFault, 1'b1);
        checkRead("ramUnchanged", 32'h0, 32'hA5A5A5A5);
        checkRead("statusFault", StatAddr, StEmpty | 32'h8);
        store(StatAddr, 32'h8, 4'hF);
        #1;
        checkEq("faultClear", AccessFault, 1'b0);

        store(32'h12, 32'hFFFFFFFF, 4'hF);
        #1;
        checkEq("misalignFault", AccessFault, 1'b1);
        checkRead("misalignNoWrite", 32'h10, 32'h12345678);
        store(StatAddr, 32'h8, 4'hF);

        ALUResult = 32'h1000;
        #1;
        checkEq("unmappedRead", ReadData, 32'h0);
        ALUResult = 32'hFFFF0010;
        #1;
        checkEq("mmioHoleRead", ReadData, 32'h0);
        tick();
        ALUResult = 32'h0;
        #1;
        checkEq("loadFault", AccessFault, 1'b1);
        store(StatAddr, 32'h8, 4'hF);
        #1;
        checkEq("loadFaultClear", AccessFault, 1'b0);

`ifdef DATA_MEM_CONSOLE_EN
        for (int i = 0; i < 9; i++) store(TxAddr, 32'h41 + i, 4'b0001);
        checkRead("statusFullOvf", StatAddr, 32'h5);
        drain("drainA", 8'h41, 8);
        #1;
        checkEq("drainedValid", ConsoleValid, 1'b0);
        checkRead("statusEmptyOvf", StatAddr, 32'h6);
        store(StatAddr, 32'h4, 4'hF);
        checkRead("ovfClear", StatAddr, 32'h2);

        for (int i = 0; i < 8; i++) store(TxAddr, 32'h50 + i, 4'b0001);
        ConsoleReady = 1'b1;
        store(TxAddr, 32'h5A, 4'b0001);
        ConsoleReady = 1'b0;
        checkRead("pushPopFull", StatAddr, 32'h1);
        drain("drainB", 8'h51, 7);
        drain("drainLast", 8'h5A, 1);

        ALUResult      = TxAddr;
        WriteData      = 32'h77;
        MemWriteSelect = 4'b0001;
        MemWrite       = 1'b1;
        #1;
        checkEq("pushNotYet", ConsoleValid, 1'b0);
        tick();
        MemWrite       = 1'b0;
        MemWriteSelect = 4'h0;
        ALUResult      = 32'h0;
        #1;
        checkEq("pushVisible", {ConsoleValid, ConsoleData}, {1'b1, 8'h77});
        store(TxAddr, 32'h78, 4'b0001);
        store(TxAddr, 32'h79, 4'b0001);
`else
        for (int i = 0; i < 9; i++) store(TxAddr, 32'h41 + i, 4'b0001);
        checkRead("txIgnored", StatAddr, 32'h3);
        #1;
        checkEq("noConsole", {ConsoleValid, ConsoleData}, 9'h0);
        checkEq("txNoFault", AccessFault, 1'b0);
`endif

        // Reset mid-traffic: stores in reset cycles are dropped, RAM survives
        reset = 1'b1;
        store(32'h20, 32'hFFFFFFFF, 4'hF);
        store(TxAddr, 32'h7A, 4'b0001);
        reset = 1'b0;
        #1;
        checkEq("midRstValid", ConsoleValid, 1'b0);
        checkEq("midRstData", ConsoleData, 8'h00);
        checkRead("midRstStatus", StatAddr, StEmpty);
        checkRead("ramKeptOnRst", 32'h20, 32'h01020304);
        repeat (3) tick();
        checkRead("cycleAfterRst", CycLo, 32'd3);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
